// File: rtl/gf_pkg.sv
// Shared GF(2^n) definitions used by the power-map engine and the other GF
// blocks.
//   - fsm_state_t / phase_t : engine FSM state and RUN sub-phase encodings
//   - GF_N / GF_POLY        : default field degree and reduction polynomial
//                             (x^6 + x + 1)
//   - gf_reduce             : reduces a carry-less product modulo a degree-n
//                             polynomial
// gf_reduce works on a fixed maximum width (GF_MAX_N). Callers zero-extend
// their operands into it and keep the low n bits of the result.
package gf_pkg;

  localparam int          GF_N      = 6;
  localparam logic [6:0]  GF_POLY   = 7'h43;
  localparam int          GF_MAX_N  = 16;
  localparam int          GF_PROD_W = 2 * GF_MAX_N - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;
  typedef enum logic       {SQ, MUL}         phase_t;

  // Long division by poly, clearing each set bit from the top down to bit n.
  // poly must include its leading x^n term.
  function automatic logic [GF_MAX_N-1:0] gf_reduce(
    input logic [GF_PROD_W-1:0] prod,
    input logic [GF_MAX_N:0]    poly,
    input int                   n
  );
    logic [GF_PROD_W-1:0] r;
    logic [GF_PROD_W-1:0] p_ext;
    r     = prod;
    p_ext = {{(GF_PROD_W-GF_MAX_N-1){1'b0}}, poly};
    for (int i = GF_PROD_W - 1; i >= 0; i--) begin
      if (i >= n && r[i]) begin
        r = r ^ (p_ext << (i - n));
      end
    end
    return r[GF_MAX_N-1:0];
  endfunction

endpackage

// File: rtl/gf2n_mult.sv
// Combinational GF(2^N) multiplier, polynomial basis.
// The block forms a carry-less N x N product and reduces it modulo POLY.
//   a, b : field elements (N bits)
//   p    : a*b mod POLY (N bits)
import gf_pkg::*;

module gf2n_mult #(
  parameter int         N    = GF_N,
  parameter logic [N:0] POLY = (N+1)'(GF_POLY)
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  logic [GF_PROD_W-1:0] clmul;
  logic [GF_MAX_N-1:0]  red;
  logic                 unused_red_hi;

  always_comb begin
    clmul = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        clmul = clmul ^ (GF_PROD_W'(a) << i);
      end
    end
    red = gf_reduce(clmul, (GF_MAX_N+1)'(POLY), N);
    p   = red[N-1:0];
  end

  // The bits of red above N are zero by construction.
  assign unused_red_hi = ^red;

endmodule

// File: rtl/gf2n_power_map_engine.sv
// Iterative, constant-time power-map engine that computes y = x^e over
// GF(2^N). It uses left-to-right square-and-multiply. Each exponent bit,
// taken MSB first, costs two cycles: a SQ cycle and a MUL cycle. The multiply
// is always evaluated, so timing does not depend on the operand values.
// out_valid rises 2*EXP_W+1 cycles after the accepting edge. The extra cycle
// is spent in DONE, where the result is registered onto y_o.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready only while IDLE
//   x_i, exp_i           base and exponent, sampled on accept
//   out_valid/out_ready  result handshake; y_o held while out_valid=1
//   y_o                  x^e
//   busy_o               high in RUN and DONE
//
// Build option SMS_FIXED_EXP_EN: when defined, the exponent register loads
// FIXED_EXP[EXP_W-1:0] on accept and exp_i is ignored.
import gf_pkg::*;

module gf2n_power_map_engine #(
  parameter int          N         = GF_N,
  parameter logic [N:0]  POLY      = (N+1)'(GF_POLY),
  parameter int          EXP_W     = 6,
  parameter int unsigned FIXED_EXP = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     y_o,
  output logic             busy_o
);

  localparam int               IDX_W   = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [N-1:0]     GF_ONE  = N'(1);

  fsm_state_t       state, state_nxt;
  phase_t           phase;
  logic [N-1:0]     acc, base, op_b, prod, y_q;
  logic [EXP_W-1:0] e_q, e_load;
  logic [IDX_W-1:0] idx;
  logic             out_valid_q;
  logic             accept, last_step;
  logic             unused_cfg;

`ifdef SMS_FIXED_EXP_EN
  assign e_load     = EXP_W'(FIXED_EXP);
  assign unused_cfg = ^exp_i;
`else
  assign e_load     = exp_i;
  assign unused_cfg = ^(EXP_W'(FIXED_EXP));
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (phase == MUL) && (idx == '0);

  // SQ and MUL share one multiplier, so only the second operand is muxed.
  assign op_b = (phase == SQ) ? acc : base;

  gf2n_mult #(.N(N), .POLY(POLY)) u_mult (
    .a (acc),
    .b (op_b),
    .p (prod)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                   state_nxt = RUN;
      RUN:     if (last_step)                state_nxt = DONE;
      DONE:    if (out_valid_q && out_ready) state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase       <= SQ;
      idx         <= '0;
      acc         <= '0;
      base        <= '0;
      e_q         <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            base  <= x_i;
            e_q   <= e_load;
            acc   <= GF_ONE;
            idx   <= IDX_TOP;
            phase <= SQ;
          end
        end
        RUN: begin
          if (phase == SQ) begin
            acc   <= prod;
            phase <= MUL;
          end else begin
            if (e_q[idx]) acc <= prod;
            phase <= SQ;
            // The index stops at 0, because leaving MUL at index 0 ends RUN.
            if (idx != '0) idx <= idx - IDX_ONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            y_q         <= acc;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign y_o       = y_q;
  assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_gf2n_power_map_engine.sv
module tb_gf2n_power_map_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [5:0] x_i = '0;
  logic [5:0] exp_i = '0;
  logic       in_ready, out_valid, busy_o;
  logic [5:0] y_o;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  logic [5:0] sb_q[$];

`ifdef SMS_FIXED_EXP_EN
  localparam bit FIXED_MODE = 1'b1;
`else
  localparam bit FIXED_MODE = 1'b0;
`endif

  gf2n_power_map_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_i       (x_i),
    .exp_i     (exp_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_o       (y_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: shift-and-add multiply, and a power by repeated multiplication.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r = r ^ t;
      t = t[5] ? ({t[4:0], 1'b0} ^ 6'h03) : {t[4:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_pow(input logic [5:0] x, input int e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < e; i++) r = ref_mul(r, x);
    return r;
  endfunction

  function automatic int eff_exp(input int e);
    return FIXED_MODE ? 20 : e;
  endfunction

  task automatic send(input logic [5:0] x, input logic [5:0] e, input logic [5:0] ye,
                      output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x_i = x;
    exp_i = e;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
    end
    acc_cyc = cyc + 1;
    sb_q.push_back(ye);
    @(negedge clk);
    in_valid = 1'b0;
    x_i = 6'($urandom);
    exp_i = 6'($urandom);
  endtask

  task automatic get_result(input int acc_cyc, input int hold, input string tag);
    int n;
    logic [5:0] y0, ye;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b, required 1 within 100 cycles", tag, out_valid);
      sb_q.delete();
      return;
    end
    checks++;
    if (cyc - acc_cyc != 13) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles, required 13", tag, cyc - acc_cyc);
    end
    y0 = y_o;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard: unexpected result y=%h, required no output", tag, y0);
    end else begin
      ye = sb_q.pop_front();
      if (y0 !== ye) begin
        errors++;
        $display("FAIL %s_value: y_o=%h, required %h", tag, y0, ye);
      end
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      x_i = 6'($urandom);
      exp_i = 6'($urandom);
      @(negedge clk);
      checks++;
      if (y_o !== y0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL %s_hold: y_o=%h out_valid=%b in_ready=%b busy=%b, required %h 1 0 1",
                 tag, y_o, out_valid, in_ready, busy_o, y0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0",
               tag, out_valid, in_ready, busy_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || y_o !== 6'h00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b y_o=%h busy=%b, required 0 0 00 0",
               in_ready, out_valid, y_o, busy_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy_o);
    end
  endtask

  task automatic test_directed();
    logic [5:0] tx[6] = '{6'h02, 6'h02, 6'h21, 6'h00, 6'h00, 6'h01};
    logic [5:0] te[6] = '{6'd20, 6'd62, 6'd62, 6'd0,  6'd20, 6'd63};
    logic [5:0] ty[6] = '{6'h3C, 6'h21, 6'h02, 6'h01, 6'h00, 6'h01};
    int ac;
    logic [5:0] ye;
    for (int i = 0; i < 6; i++) begin
      ye = FIXED_MODE ? ref_pow(tx[i], 20) : ty[i];
      send(tx[i], te[i], ye, ac);
      get_result(ac, 0, "directed");
    end
  endtask

  task automatic test_backpressure();
    int ac;
    send(6'h02, 6'd20, 6'h3C, ac);
    get_result(ac, 5, "backpressure");
  endtask

  task automatic test_reset_abort();
    int ac;
    bit seen;
    send(6'h02, 6'd20, 6'h3C, ac);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || y_o !== 6'h00 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset_state: in_ready=%b out_valid=%b y_o=%h busy=%b, required 0 0 00 0",
               in_ready, out_valid, y_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_output: spurious activity=%b in_ready=%b, required 0 1", seen, in_ready);
    end
    send(6'h02, 6'd20, 6'h3C, ac);
    get_result(ac, 0, "after_abort");
  endtask

  task automatic test_sweep();
    int elist[3] = '{1, 20, 62};
    int ac, e;
    logic [5:0] xv, ed;
    for (int j = 0; j < 3; j++) begin
      if (FIXED_MODE && j != 1) continue;
      e = elist[j];
      for (int x = 0; x < 64; x++) begin
        xv = 6'(x);
        ed = FIXED_MODE ? 6'($urandom) : 6'(e);
        send(xv, ed, ref_pow(xv, eff_exp(e)), ac);
        get_result(ac, $urandom_range(0, 3), "sweep");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_abort();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
